// File: rtl/dds_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dds_pkg: shared waveform encoding, default widths and latency of the DDS.
// Revision 1.0
// ---------------------------------------------------------------------------
package dds_pkg;

  localparam int PHASE_W_DEF    = 24;
  localparam int OUT_W_DEF      = 12;
  localparam int LUT_AW_DEF     = 8;
  localparam int TUNE_SHIFT_DEF = 8;
  localparam int SAMPLE_DIV_DEF = 50;
  localparam int PIPE_LAT       = 3;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_SAW    = 2'b11
  } wave_e;

  typedef struct packed {
    wave_e      wave;
    logic [7:0] code;
  } cfg_t;

endpackage
`default_nettype wire

// File: rtl/dds_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dds_if: valid/ready sample stream from the DDS to the DAC or sample FIFO.
// Revision 1.0
// ---------------------------------------------------------------------------
interface dds_if
  import dds_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) ();

  logic [OUT_W-1:0] sample_data;
  logic             sample_valid;
  logic             sample_ready;

  modport master (output sample_data, output sample_valid, input  sample_ready);
  modport slave  (input  sample_data, input  sample_valid, output sample_ready);

endinterface
`default_nettype wire

// File: rtl/dds_sine_rom.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dds_sine_rom: quarter-wave sine table with half-step offset, registered read.
// Revision 1.0
// ---------------------------------------------------------------------------
module dds_sine_rom
  import dds_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LUT_AW-1:0] i_addr,
  output logic [OUT_W-2:0]  o_data
);

  // Taylor series keeps table generation free of tool-specific math builtins.
  function automatic logic [OUT_W-2:0] f_rom_val(input int k);
    real x;
    real term;
    real acc;
    x    = (real'(k) + 0.5) * 3.14159265358979323846 / real'(2 ** (LUT_AW + 1));
    term = x;
    acc  = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return (OUT_W-1)'($rtoi(acc * real'(2 ** (OUT_W - 1) - 1) + 0.5));
  endfunction

  logic [OUT_W-2:0] w_rom [2**LUT_AW];
  logic [OUT_W-2:0] r_data;

  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    localparam logic [OUT_W-2:0] C_VAL = f_rom_val(k);
    assign w_rom[k] = C_VAL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else begin
      r_data <= w_rom[i_addr];
    end
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/dds_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dds_core: phase-accumulator synthesizer (sine/square/triangle/saw), 3-stage.
// Revision 1.0
// ---------------------------------------------------------------------------
module dds_core
  import dds_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int LUT_AW     = LUT_AW_DEF,
  parameter int TUNE_SHIFT = TUNE_SHIFT_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [9:0]   i_cfg_word,
  dds_if.master        smp_if,
  output logic [15:0]  o_overrun_cnt
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int TOP_W = (OUT_W + 1 > LUT_AW + 2) ? OUT_W + 1 : LUT_AW + 2;
  localparam logic [OUT_W-1:0] AMP = {1'b0, {(OUT_W-1){1'b1}}};

  logic [DIV_W-1:0]   r_div;
  logic               w_strobe;
  cfg_t               r_act;
  cfg_t               w_cfg_in;
  cfg_t               w_eff;
  logic               w_idle;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_inc;
  logic [PHASE_W-1:0] w_sum;
  logic               w_carry;

  logic               r_s1_vld;
  wave_e              r_s1_wave;
  logic [TOP_W-1:0]   r_s1_top;
  logic [LUT_AW-1:0]  w_idx;
  logic [LUT_AW-1:0]  w_addr;

  logic               r_s2_vld;
  wave_e              r_s2_wave;
  logic [OUT_W:0]     r_s2_top;
  logic [OUT_W-2:0]   w_rom;

  logic [OUT_W-1:0]   w_tri;
  logic [OUT_W-1:0]   w_sine_mag;
  logic [OUT_W-1:0]   w_res;
  logic [OUT_W-1:0]   r_data;
  logic               r_valid;
  logic [15:0]        r_ovr;

  assign w_strobe = (r_div == DIV_W'(SAMPLE_DIV - 1));
  assign w_cfg_in = cfg_t'(i_cfg_word);
  assign w_idle   = (r_act.code == 8'd0);
  // An idle config has no phase to protect, so a new word applies in the same strobe.
  assign w_eff    = w_idle ? w_cfg_in : r_act;
  assign w_inc    = {{(PHASE_W-8){1'b0}}, w_eff.code} << TUNE_SHIFT;
  assign {w_carry, w_sum} = {1'b0, r_phase} + {1'b0, w_inc};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div     <= '0;
      r_phase   <= '0;
      r_act     <= '{wave: WAVE_SINE, code: 8'd0};
      r_s1_vld  <= 1'b0;
      r_s1_wave <= WAVE_SINE;
      r_s1_top  <= '0;
    end else begin
      r_div    <= w_strobe ? '0 : r_div + 1'b1;
      r_s1_vld <= w_strobe;
      if (w_strobe) begin
        r_phase   <= w_sum;
        r_s1_top  <= w_sum[PHASE_W-1 -: TOP_W];
        r_s1_wave <= w_eff.wave;
        if (w_carry || w_idle) begin
          r_act <= w_cfg_in;
        end
      end
    end
  end

  // Odd quadrants read the table backwards.
  assign w_idx  = r_s1_top[TOP_W-3 -: LUT_AW];
  assign w_addr = r_s1_top[TOP_W-2] ? ~w_idx : w_idx;

  dds_sine_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .i_addr  (w_addr),
    .o_data  (w_rom)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_wave <= WAVE_SINE;
      r_s2_top  <= '0;
    end else begin
      r_s2_vld  <= r_s1_vld;
      r_s2_wave <= r_s1_wave;
      r_s2_top  <= r_s1_top[TOP_W-1 -: OUT_W+1];
    end
  end

  always_comb begin
    w_res      = '0;
    w_sine_mag = {1'b0, w_rom};
    w_tri      = r_s2_top[OUT_W-1:0];
    if (r_s2_top[OUT_W]) begin
      w_tri = ~w_tri;
    end
    case (r_s2_wave)
      WAVE_SINE:   w_res = r_s2_top[OUT_W] ? -w_sine_mag : w_sine_mag;
      WAVE_SQUARE: w_res = r_s2_top[OUT_W] ? -AMP : AMP;
      WAVE_TRI:    w_res = {~w_tri[OUT_W-1], w_tri[OUT_W-2:0]};
      default:     w_res = {~r_s2_top[OUT_W], r_s2_top[OUT_W-1 -: OUT_W-1]};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= '0;
    end else if (r_s2_vld) begin
      r_data  <= w_res;
      r_valid <= 1'b1;
      if (r_valid && !smp_if.sample_ready && (r_ovr != 16'hFFFF)) begin
        r_ovr <= r_ovr + 16'd1;
      end
    end else if (r_valid && smp_if.sample_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign smp_if.sample_data  = r_data;
  assign smp_if.sample_valid = r_valid;
  assign o_overrun_cnt       = r_ovr;

endmodule
`default_nettype wire
